// File: rtl/dose_scheduler_if.sv
// Dispense handshake between the dose scheduler (master) and the dispenser
// motor controller (slave): level request, slot number, level acknowledge.
interface dose_scheduler_if #(
    parameter int SW = 2
);
    logic          dispense_req;
    logic [SW-1:0] dispense_slot;
    logic          dispense_ack;

    modport master (
        output dispense_req,
        output dispense_slot,
        input  dispense_ack
    );

    modport slave (
        input  dispense_req,
        input  dispense_slot,
        output dispense_ack
    );
endinterface

// File: rtl/dose_scheduler.sv
// Dose scheduler: matches the time of day against programmable dose slots and
// drives a req/ack dispense handshake with timeout, retry and missed-dose alarm.
module dose_scheduler #(
    parameter  int NUM_SLOTS   = 4,
    parameter  int ACK_TIMEOUT = 10,
    parameter  int MAX_RETRY   = 2,
    localparam int SW          = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 second_pulse,
    input  logic [4:0]           hours,
    input  logic [5:0]           minutes,
    input  logic [5:0]           seconds,
    input  logic                 set_mode,
    input  logic                 prog_we,
    input  logic [SW-1:0]        prog_slot,
    input  logic [4:0]           prog_hours,
    input  logic [5:0]           prog_minutes,
    input  logic                 prog_enable,
    dose_scheduler_if.master     disp,
    input  logic                 alarm_clr,
    output logic [NUM_SLOTS-1:0] alarm,
    output logic [NUM_SLOTS-1:0] pending,
    output logic                 busy
);

    localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RETRY,
        S_RELEASE
    } state_t;

    state_t               state, state_nxt;
    logic                 tick_d;
    logic [4:0]           slot_h [NUM_SLOTS];
    logic [5:0]           slot_m [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_en;
    logic [SW-1:0]        cur_slot, slot_nxt;
    logic [TW-1:0]        tmo_cnt, tmo_nxt;
    logic [RW-1:0]        retry_cnt, retry_nxt;

    logic [NUM_SLOTS-1:0] match;
    logic [NUM_SLOTS-1:0] serve_clr;
    logic [NUM_SLOTS-1:0] prog_clr;
    logic [NUM_SLOTS-1:0] alarm_set;
    logic [NUM_SLOTS-1:0] pending_nxt;
    logic [NUM_SLOTS-1:0] alarm_nxt;
    logic [SW-1:0]        first_slot;

    // The time counters settle one cycle after the strobe, so matching uses tick_d.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            match[i] = tick_d && !set_mode && slot_en[i] &&
                       (hours == slot_h[i]) && (minutes == slot_m[i]) &&
                       (seconds == 6'd0);
        end
    end

    always_comb begin
        first_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (pending[i]) first_slot = SW'(i);
        end
    end

    // The slot owned by an active handshake keeps its pending bit across a rewrite.
    always_comb begin
        prog_clr = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (prog_we && (prog_slot == SW'(i)) &&
                !((state != S_IDLE) && (cur_slot == SW'(i))))
                prog_clr[i] = 1'b1;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        slot_nxt  = cur_slot;
        tmo_nxt   = tmo_cnt;
        retry_nxt = retry_cnt;
        serve_clr = '0;
        alarm_set = '0;
        case (state)
            S_IDLE: begin
                if ((pending != '0) && !set_mode) begin
                    state_nxt = S_REQ;
                    slot_nxt  = first_slot;
                    tmo_nxt   = '0;
                    retry_nxt = '0;
                end
            end
            S_REQ: begin
                if (disp.dispense_ack) begin
                    serve_clr[cur_slot] = 1'b1;
                    state_nxt           = S_RELEASE;
                end else if (tmo_cnt == TW'(ACK_TIMEOUT)) begin
                    if (retry_cnt < RW'(MAX_RETRY)) begin
                        retry_nxt = retry_cnt + 1'b1;
                        state_nxt = S_RETRY;
                    end else begin
                        alarm_set[cur_slot] = 1'b1;
                        serve_clr[cur_slot] = 1'b1;
                        state_nxt           = S_IDLE;
                    end
                end else if (second_pulse) begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
            S_RETRY: begin
                tmo_nxt   = '0;
                state_nxt = S_REQ;
            end
            S_RELEASE: begin
                if (!disp.dispense_ack) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // A fresh match beats any clear of the same bit; a new alarm beats alarm_clr.
        pending_nxt = (pending & ~(serve_clr | prog_clr)) | match;
        alarm_nxt   = (alarm_clr ? '0 : alarm) | alarm_set;
    end

    assign disp.dispense_req  = (state == S_REQ);
    assign disp.dispense_slot = cur_slot;
    assign busy               = (state != S_IDLE);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            tick_d    <= 1'b0;
            cur_slot  <= '0;
            tmo_cnt   <= '0;
            retry_cnt <= '0;
            pending   <= '0;
            alarm     <= '0;
        end else begin
            tick_d    <= second_pulse;
            cur_slot  <= slot_nxt;
            tmo_cnt   <= tmo_nxt;
            retry_cnt <= retry_nxt;
            pending   <= pending_nxt;
            alarm     <= alarm_nxt;
        end
    end

    // NOTE: the slot table is a handful of flops, not RAM, and is reset so no stale slot is armed.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            slot_en <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_h[i] <= '0;
                slot_m[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (prog_we && (prog_slot == SW'(i))) begin
                    slot_h[i]  <= prog_hours;
                    slot_m[i]  <= prog_minutes;
                    slot_en[i] <= prog_enable;
                end
            end
        end
    end

endmodule

// File: tb/tb_dose_scheduler.sv
// Directed bench for dose_scheduler: expected dispense/alarm events go into a
// scoreboard queue that a negedge monitor pops; direct checks cover timing.
module tb_dose_scheduler;

    localparam int NUM_SLOTS = 4;
    localparam int SW        = 2;
    localparam int ALARM_EV  = 16;

    logic                 CLOCK_50 = 1'b0;
    logic                 reset    = 1'b1;
    logic                 second_pulse;
    logic [4:0]           hours;
    logic [5:0]           minutes;
    logic [5:0]           seconds;
    logic                 set_mode;
    logic                 prog_we;
    logic [SW-1:0]        prog_slot;
    logic [4:0]           prog_hours;
    logic [5:0]           prog_minutes;
    logic                 prog_enable;
    logic                 alarm_clr;
    logic [NUM_SLOTS-1:0] alarm;
    logic [NUM_SLOTS-1:0] pending;
    logic                 busy;

    dose_scheduler_if #(.SW(SW)) disp ();

    dose_scheduler #(
        .NUM_SLOTS   (NUM_SLOTS),
        .ACK_TIMEOUT (10),
        .MAX_RETRY   (2)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .second_pulse (second_pulse),
        .hours        (hours),
        .minutes      (minutes),
        .seconds      (seconds),
        .set_mode     (set_mode),
        .prog_we      (prog_we),
        .prog_slot    (prog_slot),
        .prog_hours   (prog_hours),
        .prog_minutes (prog_minutes),
        .prog_enable  (prog_enable),
        .disp         (disp),
        .alarm_clr    (alarm_clr),
        .alarm        (alarm),
        .pending      (pending),
        .busy         (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_pop(input string name, input int act);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected event %0d with empty scoreboard (t=%0t)", name, act, $time);
        end else begin
            check(name, 32'(act), 32'(exp_q.pop_front()));
        end
    endtask

    // Monitor: every rising dispense_req and every newly set alarm bit is an event.
    logic                 req_q   = 1'b0;
    logic [NUM_SLOTS-1:0] alarm_q = '0;
    always @(negedge CLOCK_50) begin
        if (disp.dispense_req && !req_q) sb_pop("req_event", int'(disp.dispense_slot));
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (alarm[i] && !alarm_q[i]) sb_pop("alarm_event", ALARM_EV + i);
        end
        req_q   = disp.dispense_req;
        alarm_q = alarm;
    end

    task automatic prog(input int slot, input int h, input int m, input logic en);
        @(negedge CLOCK_50);
        prog_we      = 1'b1;
        prog_slot    = SW'(slot);
        prog_hours   = 5'(h);
        prog_minutes = 6'(m);
        prog_enable  = en;
        @(negedge CLOCK_50);
        prog_we      = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        @(negedge CLOCK_50);
        hours   = 5'(h);
        minutes = 6'(m);
        seconds = 6'(s);
    endtask

    // Strobe, then present the new time on the following cycle like the clock counters.
    task automatic sec(input int h, input int m, input int s);
        @(negedge CLOCK_50);
        second_pulse = 1'b1;
        @(negedge CLOCK_50);
        second_pulse = 1'b0;
        hours        = 5'(h);
        minutes      = 6'(m);
        seconds      = 6'(s);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!disp.dispense_req && n < 40) begin
            @(negedge CLOCK_50);
            n++;
        end
        check(name, 32'(disp.dispense_req), 32'd1);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   win_pulses[8];
        int   n_win;
        int   low_run;
        logic prev_r;
        logic r;

        second_pulse      = 1'b0;
        hours             = '0;
        minutes           = '0;
        seconds           = '0;
        set_mode          = 1'b0;
        prog_we           = 1'b0;
        prog_slot         = '0;
        prog_hours        = '0;
        prog_minutes      = '0;
        prog_enable       = 1'b0;
        alarm_clr         = 1'b0;
        disp.dispense_ack = 1'b0;

        repeat (3) @(negedge CLOCK_50);
        check("rst_req",     32'(disp.dispense_req),  32'd0);
        check("rst_slot",    32'(disp.dispense_slot), 32'd0);
        check("rst_pending", 32'(pending),            32'd0);
        check("rst_alarm",   32'(alarm),              32'd0);
        check("rst_busy",    32'(busy),               32'd0);
        reset = 1'b0;

        // 1: single dose at 08:30 with exact handshake timing
        prog(1, 8, 30, 1'b1);
        set_time(8, 29, 59);
        exp_q.push_back(1);
        sec(8, 30, 0);
        @(negedge CLOCK_50);
        check("t1_pending_set", 32'(pending), 32'h2);
        check("t1_not_busy",    32'(busy),    32'd0);
        @(negedge CLOCK_50);
        check("t1_req_rise", 32'(disp.dispense_req),  32'd1);
        check("t1_req_slot", 32'(disp.dispense_slot), 32'd1);
        disp.dispense_ack = 1'b1;
        @(negedge CLOCK_50);
        check("t1_req_fall",    32'(disp.dispense_req), 32'd0);
        check("t1_pending_clr", 32'(pending),           32'd0);
        check("t1_release",     32'(busy),              32'd1);
        disp.dispense_ack = 1'b0;
        @(negedge CLOCK_50);
        check("t1_idle", 32'(busy), 32'd0);

        // 2: two slots at 12:00, lowest index served first
        prog(0, 12, 0, 1'b1);
        prog(2, 12, 0, 1'b1);
        set_time(11, 59, 59);
        exp_q.push_back(0);
        exp_q.push_back(2);
        sec(12, 0, 0);
        @(negedge CLOCK_50);
        check("t2_both_pending", 32'(pending), 32'h5);
        wait_req("t2_req0_wait");
        check("t2_first_slot", 32'(disp.dispense_slot), 32'd0);
        disp.dispense_ack = 1'b1;
        @(negedge CLOCK_50);
        check("t2_pending_after0", 32'(pending),           32'h4);
        check("t2_req_drop",       32'(disp.dispense_req), 32'd0);
        disp.dispense_ack = 1'b0;
        wait_req("t2_req2_wait");
        check("t2_second_slot", 32'(disp.dispense_slot), 32'd2);
        disp.dispense_ack = 1'b1;
        @(negedge CLOCK_50);
        disp.dispense_ack = 1'b0;
        @(negedge CLOCK_50);
        check("t2_pending_done", 32'(pending), 32'd0);
        check("t2_idle",         32'(busy),    32'd0);

        // 3: never acknowledged: three 10-second windows, then the alarm
        prog(3, 9, 0, 1'b1);
        set_time(8, 59, 59);
        exp_q.push_back(3);
        exp_q.push_back(3);
        exp_q.push_back(3);
        exp_q.push_back(ALARM_EV + 3);
        sec(9, 0, 0);
        for (int k = 0; k < 8; k++) win_pulses[k] = 0;
        n_win   = 0;
        low_run = 0;
        prev_r  = 1'b0;
        for (int cyc = 0; cyc < 220; cyc++) begin
            @(negedge CLOCK_50);
            r = disp.dispense_req;
            if (r && !prev_r) begin
                if (n_win > 0) check("t3_drop_len", 32'(low_run), 32'd1);
                if (n_win < 8) n_win++;
                low_run = 0;
            end
            if (!r) low_run++;
            second_pulse = (cyc % 4 == 0);
            if (cyc % 4 == 1) seconds = seconds + 6'd1;
            if (r && second_pulse && n_win >= 1) win_pulses[n_win-1]++;
            prev_r = r;
        end
        second_pulse = 1'b0;
        check("t3_windows",  32'(n_win),         32'd3);
        check("t3_win0",     32'(win_pulses[0]), 32'd10);
        check("t3_win1",     32'(win_pulses[1]), 32'd10);
        check("t3_win2",     32'(win_pulses[2]), 32'd10);
        check("t3_alarm",    32'(alarm),         32'h8);
        check("t3_pending",  32'(pending),       32'd0);
        check("t3_idle",     32'(busy),          32'd0);
        @(negedge CLOCK_50);
        alarm_clr = 1'b1;
        @(negedge CLOCK_50);
        alarm_clr = 1'b0;
        check("t3_alarm_clr", 32'(alarm), 32'd0);

        // 4: set_mode suspends matching; a disabled slot never matches
        prog(3, 7, 0, 1'b1);
        set_mode = 1'b1;
        set_time(6, 59, 59);
        sec(7, 0, 0);
        repeat (4) @(negedge CLOCK_50);
        check("t4_setmode_pending", 32'(pending), 32'd0);
        check("t4_setmode_busy",    32'(busy),    32'd0);
        set_mode = 1'b0;
        prog(3, 7, 0, 1'b0);
        set_time(6, 59, 59);
        sec(7, 0, 0);
        repeat (4) @(negedge CLOCK_50);
        check("t4_disabled_pending", 32'(pending), 32'd0);
        check("t4_disabled_busy",    32'(busy),    32'd0);

        // 5: reset in the middle of a request
        prog(0, 10, 0, 1'b1);
        set_time(9, 59, 59);
        exp_q.push_back(0);
        sec(10, 0, 0);
        wait_req("t5_req_wait");
        check("t5_pending_in_req", 32'(pending), 32'h1);
        reset = 1'b1;
        @(negedge CLOCK_50);
        check("t5_req_drop", 32'(disp.dispense_req), 32'd0);
        check("t5_pending",  32'(pending),           32'd0);
        check("t5_alarm",    32'(alarm),             32'd0);
        check("t5_busy",     32'(busy),              32'd0);
        reset = 1'b0;
        set_time(9, 59, 59);
        sec(10, 0, 0);
        repeat (4) @(negedge CLOCK_50);
        check("t5_slot0_disabled", 32'(pending), 32'd0);
        set_time(8, 29, 59);
        sec(8, 30, 0);
        repeat (4) @(negedge CLOCK_50);
        check("t5_slot1_disabled", 32'(pending), 32'd0);

        // 6a: ack clearing pending[0] on the same edge as a fresh match: set wins
        prog(0, 11, 0, 1'b1);
        set_time(10, 59, 59);
        exp_q.push_back(0);
        exp_q.push_back(0);
        sec(11, 0, 0);
        wait_req("t6_req_wait");
        second_pulse = 1'b1;
        @(negedge CLOCK_50);
        second_pulse      = 1'b0;
        disp.dispense_ack = 1'b1;
        @(negedge CLOCK_50);
        check("t6_set_wins", 32'(pending),           32'h1);
        check("t6_req_fall", 32'(disp.dispense_req), 32'd0);
        disp.dispense_ack = 1'b0;
        wait_req("t6_reserve_wait");
        disp.dispense_ack = 1'b1;
        @(negedge CLOCK_50);
        disp.dispense_ack = 1'b0;
        @(negedge CLOCK_50);
        check("t6_served",  32'(pending), 32'd0);
        check("t6_idle",    32'(busy),    32'd0);

        // 6b: rewriting an idle pending slot drops its pending bit
        prog(2, 13, 0, 1'b1);
        set_time(12, 59, 59);
        sec(13, 0, 0);
        @(negedge CLOCK_50);
        check("t6_slot2_pending", 32'(pending), 32'h4);
        set_mode     = 1'b1;
        prog_we      = 1'b1;
        prog_slot    = 2'd2;
        prog_hours   = 5'd13;
        prog_minutes = 6'd0;
        prog_enable  = 1'b1;
        @(negedge CLOCK_50);
        prog_we = 1'b0;
        check("t6_rewrite_clr", 32'(pending), 32'd0);
        check("t6_rewrite_idle", 32'(busy),   32'd0);
        set_mode = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("t6_stays_idle", 32'(busy), 32'd0);

        repeat (2) @(negedge CLOCK_50);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dose_scheduler.md
Name: dose_scheduler

Overview:
- Consumes the time-of-day interface driven by the clock counters: hours, minutes, seconds and the one-cycle second strobe.
- Holds NUM_SLOTS programmable dose times and raises a dispense request to the dispenser motor controller when the current time matches an enabled slot.
- Runs a req/ack handshake with the dispenser, including timeout, retry and a sticky missed-dose alarm.
- Sits between the clock/set-time logic and the dispenser actuator.

Parameters:
NUM_SLOTS, 4, number of dose slots (slot index width SW = clog2(NUM_SLOTS))
ACK_TIMEOUT, 10, second strobes to wait in REQ for dispense_ack before a retry
MAX_RETRY, 2, extra request attempts after the first before a missed-dose alarm is raised

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
second_pulse  in  1  one-cycle strobe, once per second
hours  in  5  current hour, 0..23
minutes  in  6  current minute, 0..59
seconds  in  6  current second, 0..59
set_mode  in  1  1 = clock being edited; matching and new requests are suspended
prog_we  in  1  write strobe for the slot registers
prog_slot  in  SW  slot to write
prog_hours  in  5  slot hour
prog_minutes  in  6  slot minute
prog_enable  in  1  slot enable
dispense_req  out  1  request to dispenser
dispense_slot  out  SW  slot being dispensed; valid while dispense_req = 1
dispense_ack  in  1  dispenser acknowledge (level)
alarm_clr  in  1  clears all alarm bits
alarm  out  NUM_SLOTS  sticky missed-dose flags, one per slot
pending  out  NUM_SLOTS  doses due but not yet served
busy  out  1  FSM not in IDLE

Behaviour:
- Reset:
  - All slot registers cleared to hours = 0, minutes = 0, enable = 0.
  - pending, alarm, retry counter and timeout counter = 0.
  - dispense_req = 0, dispense_slot = 0, busy = 0; FSM in IDLE.
- Time sampling:
  - The time counters update on the cycle after second_pulse, so second_pulse is delayed one cycle (tick_d).
  - Matching is evaluated only on tick_d.
- Match rule:
  - On tick_d with set_mode = 0, for each slot i: enable[i] = 1, hours = slot_h[i], minutes = slot_m[i] and seconds = 0 -> pending[i] <= 1.
  - Several slots may match on the same tick; all of them are set.
  - Out-of-range programmed values are stored as written and simply never match.
- Programming:
  - prog_we writes the slot on the next edge and is accepted in any state.
  - Writing a slot clears its pending bit, except for the slot currently in REQ/RETRY/RELEASE, which completes normally.
- Arbitration: IDLE selects the lowest-index set pending bit.
- FSM:
  - IDLE: when pending != 0 and set_mode = 0 -> REQ. Latch dispense_slot, clear the timeout counter, clear the retry counter.
  - REQ: dispense_req = 1.
    - dispense_ack = 1 -> clear pending[slot], go to RELEASE.
    - Else, on each second_pulse the timeout counter increments.
    - When the counter reaches ACK_TIMEOUT and retry < MAX_RETRY: retry++, go to RETRY.
    - When the counter reaches ACK_TIMEOUT and retry = MAX_RETRY: alarm[slot] <= 1, clear pending[slot], go to IDLE.
  - RETRY: dispense_req = 0 for exactly one cycle, clear the timeout counter, go to REQ.
  - RELEASE: dispense_req = 0; wait for dispense_ack = 0, then go to IDLE.
- Timing:
  - dispense_req rises one cycle after IDLE sees a pending bit.
  - dispense_req falls the cycle after ack is sampled high.
  - dispense_slot is held stable from REQ entry until IDLE.
- set_mode rising while in REQ/RETRY/RELEASE does not abort the handshake.
- Simultaneous events, same cycle:
  - A match setting pending[i] together with an ack/alarm clearing pending[i]: set wins.
  - alarm_clr together with a new alarm: the new alarm bit wins and is set.
- A second match for a slot that is already pending is absorbed; there is no counting.
- reset asserted mid-handshake: dispense_req drops on the next edge and all state returns to reset values.
- busy = 1 in REQ, RETRY and RELEASE.

Test Plan:
1. Program slot 1 = 08:30, enabled; drive time 08:29:59 -> 08:30:00 with second_pulse. pending[1] = 1 one cycle after tick_d, then dispense_req = 1 with dispense_slot = 1. Ack = 1 -> req = 0 next cycle and pending[1] = 0. Ack = 0 -> busy = 0.
2. Slots 0 and 2 both programmed to 12:00 -> both pending bits set on the same tick. Slot 0 is served first, slot 2 after RELEASE completes.
3. Never ack, ACK_TIMEOUT = 10, MAX_RETRY = 2. Exactly 3 request windows of 10 seconds each, separated by one-cycle req drops. Then alarm[slot] = 1, pending cleared, busy = 0. alarm_clr -> alarm = 0.
4. set_mode = 1 across 07:00:00 with slot 3 = 07:00 -> pending stays 0 and no req. Slot 3 disabled -> no match either.
5. Assert reset while in REQ -> next edge dispense_req = 0, pending = 0, alarm = 0, and every slot reads disabled.
6. Same cycle: ack clears pending[0] while tick_d matches slot 0 again -> pending[0] = 1 afterwards. Rewriting slot 2 via prog_we while it is pending and idle -> pending[2] = 0.
